// File: rtl/mult_booth16_pkg.sv
// Shared constants and types for the sequential radix-2 Booth multiplier.
package mult_booth16_pkg;
  localparam int WIDTH = 16;
  localparam int ITER  = 16;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Booth working set: 17-bit accumulator, multiplier shift register, Q[-1]
  typedef struct packed {
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             qm1;
  } booth_t;
endpackage

// File: rtl/mult_booth16_if.sv
// Start/operand request and result/status response bundle of the multiplier.
interface mult_booth16_if;
  logic        ctrl_start;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        data_ready;
  logic [31:0] result;
  logic        ovf16;

  modport master (output ctrl_start, operand_a, operand_b,
                  input  busy, data_ready, result, ovf16);
  modport slave  (input  ctrl_start, operand_a, operand_b,
                  output busy, data_ready, result, ovf16);
endinterface

// File: rtl/CSA_16.sv
// 16-bit carry-select adder: rippled low byte, high byte precomputed for both carries.
module CSA_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [8:0] lo, hi0, hi1;

  assign lo  = {1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'b0, cin};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
  assign cout = lo[8] ? hi1[8] : hi0[8];
endmodule

// File: rtl/mult_booth16_booth_step.sv
// One combinational Booth iteration: add/sub M via CSA_16, extend to 17 bits, shift right.
module mult_booth16_booth_step
  import mult_booth16_pkg::*;
(
  input  logic [WIDTH-1:0] m,
  input  booth_t           cur,
  output booth_t           nxt
);
  logic             add, sub, cout, a_hi;
  logic [WIDTH-1:0] opnd, sum;
  logic [WIDTH:0]   a_new;

  assign add  = ~cur.q[0] & cur.qm1;
  assign sub  =  cur.q[0] & ~cur.qm1;
  assign opnd = sub ? ~m : (add ? m : '0);

  CSA_16 u_add (
    .a    (cur.a[WIDTH-1:0]),
    .b    (opnd),
    .cin  (sub),
    .sum  (sum),
    .cout (cout)
  );

  // Sign bit of the 17-bit sum from the sign-extended operand and adder carry
  assign a_hi  = cur.a[WIDTH] ^ opnd[WIDTH-1] ^ cout;
  assign a_new = {a_hi, sum};

  always_comb begin
    nxt     = '0;
    nxt.a   = {a_new[WIDTH], a_new[WIDTH:1]};
    nxt.q   = {a_new[0], cur.q[WIDTH-1:1]};
    nxt.qm1 = cur.q[0];
  end
endmodule

// File: rtl/mult_booth16.sv
// Sequential signed 16x16 Booth multiplier: FSM, iteration counter and product registers.
module mult_booth16
  import mult_booth16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  mult_booth16_if.slave  bus
);
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m;
  booth_t           cur, nxt;
  logic [31:0]      res;
  logic             ovf;
  logic [16:0]      top_bits;

  mult_booth16_booth_step u_step (
    .m   (m),
    .cur (cur),
    .nxt (nxt)
  );

  // Bits that must all match the sign for the product to fit in 16 bits
  assign top_bits = {cur.a[15:0], cur.q[15]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      m     <= '0;
      cur   <= '0;
      res   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.ctrl_start) begin
          m       <= bus.operand_a;
          cur.a   <= '0;
          cur.q   <= bus.operand_b;
          cur.qm1 <= 1'b0;
          cnt     <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: if (cnt < CNT_W'(ITER)) begin
          cur <= nxt;
          cnt <= cnt + 1'b1;
        end else begin
          res   <= {cur.a[15:0], cur.q};
          ovf   <= ~((&top_bits) | ~(|top_bits));
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == ST_RUN) || (state == ST_DONE);
  assign bus.data_ready = (state == ST_DONE);
  assign bus.result     = res;
  assign bus.ovf16      = ovf;
endmodule
